// File: rtl/req_queue_pkg.sv
// Shared constants and instruction-field helpers for the request dispatch queue.
package req_queue_pkg;

    // Opcode values that select a destination channel.
    localparam int unsigned OP_AES = 0;
    localparam int unsigned OP_SHA = 1;

    // Width of one queued instruction: {opcode, key_addr, text_addr}.
    function automatic int unsigned calc_instrw(int unsigned addrw, int unsigned opcodew);
        return 2 * addrw + opcodew;
    endfunction

    // Field extractors; the instruction is zero-extended to 64 bits by the caller.
    function automatic logic [63:0] field_opcode(logic [63:0] instr, int unsigned addrw,
                                                 int unsigned opcodew);
        logic [63:0] mask;
        mask = (64'd1 << opcodew) - 64'd1;
        return (instr >> (2 * addrw)) & mask;
    endfunction

    function automatic logic [63:0] field_key_addr(logic [63:0] instr, int unsigned addrw);
        logic [63:0] mask;
        mask = (64'd1 << addrw) - 64'd1;
        return (instr >> addrw) & mask;
    endfunction

    function automatic logic [63:0] field_text_addr(logic [63:0] instr, int unsigned addrw);
        logic [63:0] mask;
        mask = (64'd1 << addrw) - 64'd1;
        return instr & mask;
    endfunction

endpackage

// File: rtl/req_fifo.sv
// One channel FIFO: circular buffer with registered occupancy count.
module req_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CNTW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [CNTW-1:0]  count_o
);
    localparam int unsigned PTRW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             push_eff, pop_eff;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CNTW'(DEPTH));
    assign count_o = count_q;
    // Empty channel shows zeros instead of stale storage.
    assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    // Qualify handshakes so a full push or empty pop has no effect.
    assign push_eff = push_i && !full_o;
    assign pop_eff  = pop_i && valid_o;

    // Next-state pointers and count; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_eff) wr_ptr_d = wr_ptr_q + PTRW'(1);
        if (pop_eff)  rd_ptr_d = rd_ptr_q + PTRW'(1);
        unique case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset discards all entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/req_dispatch_queue.sv
// Routes instructions by opcode into per-engine FIFOs with independent handshakes.
module req_dispatch_queue
    import req_queue_pkg::*;
#(
    parameter int unsigned ADDRW   = 8,
    parameter int unsigned OPCODEW = 2,
    parameter int unsigned NCH     = 2,
    parameter int unsigned DEPTH   = 16,
    localparam int unsigned INSTRW = calc_instrw(ADDRW, OPCODEW),
    localparam int unsigned CNTW   = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [OPCODEW-1:0]    opcode,
    input  logic [ADDRW-1:0]      key_addr,
    input  logic [ADDRW-1:0]      text_addr,
    output logic                  ready_out,
    input  logic [NCH-1:0]        ready_in,
    output logic [NCH-1:0]        valid_out,
    output logic [NCH*INSTRW-1:0] instr,
    output logic [NCH*CNTW-1:0]   count,
    output logic                  err_illegal
);
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    push;
    logic [INSTRW-1:0] din;
    logic              legal;
    logic              err_q, err_d;

    assign din = {opcode, key_addr, text_addr};

    // Opcode decode and ready mux; deliberately independent of ready_in.
    always_comb begin
        legal     = 1'b0;
        ready_out = 1'b1;
        push      = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            if (opcode == OPCODEW'(c)) begin
                legal     = 1'b1;
                ready_out = !full[c];
                push[c]   = valid_in && !full[c];
            end
        end
    end

    // Sticky illegal-opcode flag; an illegal instruction is always accepted and dropped.
    always_comb begin
        err_d = err_q | (valid_in && !legal);
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_illegal = err_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        req_fifo #(
            .WIDTH (INSTRW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (push[c]),
            .din_i   (din),
            .pop_i   (ready_in[c]),
            .dout_o  (instr[c*INSTRW +: INSTRW]),
            .valid_o (valid_out[c]),
            .full_o  (full[c]),
            .count_o (count[c*CNTW +: CNTW])
        );
    end

endmodule

// File: tb/tb_req_dispatch_queue.sv
// Directed self-checking bench for req_dispatch_queue (NCH=2, DEPTH=16).
module tb_req_dispatch_queue;

    localparam int unsigned INSTRW = 18;
    localparam int unsigned CNTW   = 5;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [1:0]  opcode;
    logic [7:0]  key_addr;
    logic [7:0]  text_addr;
    logic        ready_out;
    logic [1:0]  ready_in;
    logic [1:0]  valid_out;
    logic [35:0] instr;
    logic [9:0]  count;
    logic        err_illegal;

    int checks;
    int errors;

    req_dispatch_queue #(
        .ADDRW   (8),
        .OPCODEW (2),
        .NCH     (2),
        .DEPTH   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .opcode      (opcode),
        .key_addr    (key_addr),
        .text_addr   (text_addr),
        .ready_out   (ready_out),
        .ready_in    (ready_in),
        .valid_out   (valid_out),
        .instr       (instr),
        .count       (count),
        .err_illegal (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vin;
        logic [1:0]  op;
        logic [7:0]  key;
        logic [7:0]  txt;
        logic [1:0]  rin;
        logic        exp_rdy;
        logic [1:0]  exp_vout;
        logic [4:0]  exp_c0;
        logic [4:0]  exp_c1;
        logic [17:0] exp_i0;
        logic [17:0] exp_i1;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [17:0] head(input logic [35:0] v, input int c);
        return v[c*INSTRW +: INSTRW];
    endfunction

    function automatic logic [4:0] cnt(input logic [9:0] v, input int c);
        return v[c*CNTW +: CNTW];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] k,
                         input logic [7:0] t, input logic [1:0] r);
        valid_in  = v;
        opcode    = op;
        key_addr  = k;
        text_addr = t;
        ready_in  = r;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, 8'h00, 8'h00, 2'b00);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [17:0] model_q [$];
    logic [17:0] exp_h;
    logic [17:0] ch1_first;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;

        //                 vin op  key    txt    rin   rdy vout   c0     c1     i0         i1         err
        vecs[0] = '{1'b1, 2'd1, 8'h12, 8'h34, 2'b00, 1'b1, 2'b10, 5'd0, 5'd1, 18'h00000, 18'h11234, 1'b0};
        vecs[1] = '{1'b1, 2'd0, 8'hAA, 8'h55, 2'b00, 1'b1, 2'b11, 5'd1, 5'd1, 18'h0AA55, 18'h11234, 1'b0};
        vecs[2] = '{1'b1, 2'd0, 8'h01, 8'h02, 2'b01, 1'b1, 2'b11, 5'd1, 5'd1, 18'h00102, 18'h11234, 1'b0};
        vecs[3] = '{1'b1, 2'd3, 8'h77, 8'h88, 2'b00, 1'b1, 2'b11, 5'd1, 5'd1, 18'h00102, 18'h11234, 1'b1};
        vecs[4] = '{1'b0, 2'd0, 8'h00, 8'h00, 2'b11, 1'b1, 2'b00, 5'd0, 5'd0, 18'h00000, 18'h00000, 1'b1};
        vecs[5] = '{1'b0, 2'd1, 8'h00, 8'h00, 2'b11, 1'b1, 2'b00, 5'd0, 5'd0, 18'h00000, 18'h00000, 1'b1};
        vecs[6] = '{1'b1, 2'd1, 8'h9A, 8'hBC, 2'b10, 1'b1, 2'b10, 5'd0, 5'd1, 18'h00000, 18'h19ABC, 1'b1};
        vecs[7] = '{1'b0, 2'd1, 8'h00, 8'h00, 2'b10, 1'b1, 2'b00, 5'd0, 5'd0, 18'h00000, 18'h00000, 1'b1};

        do_reset();
        #1;
        chk("reset ready_out", 32'(ready_out), 32'd1);
        chk("reset valid_out", 32'(valid_out), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset instr", 32'(instr[31:0]), 32'd0);
        chk("reset err_illegal", 32'(err_illegal), 32'd0);

        // Table-driven routing, same-cycle push/pop, illegal opcode, empty pop.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].vin, vecs[i].op, vecs[i].key, vecs[i].txt, vecs[i].rin);
            #1;
            chk($sformatf("vec%0d ready_out", i), 32'(ready_out), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d valid_out", i), 32'(valid_out), 32'(vecs[i].exp_vout));
            chk($sformatf("vec%0d count0", i), 32'(cnt(count, 0)), 32'(vecs[i].exp_c0));
            chk($sformatf("vec%0d count1", i), 32'(cnt(count, 1)), 32'(vecs[i].exp_c1));
            chk($sformatf("vec%0d instr0", i), 32'(head(instr, 0)), 32'(vecs[i].exp_i0));
            chk($sformatf("vec%0d instr1", i), 32'(head(instr, 1)), 32'(vecs[i].exp_i1));
            chk($sformatf("vec%0d err", i), 32'(err_illegal), 32'(vecs[i].exp_err));
        end

        // Fill channel 0 to full, twice, draining in order each time.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                drive(1'b1, 2'd0, 8'(i + pass * 16), 8'(~(i + pass * 16)), 2'b00);
            end
            @(negedge clk);
            drive(1'b0, 2'd0, 8'h00, 8'h00, 2'b00);
            #1;
            chk($sformatf("fill%0d count0", pass), 32'(cnt(count, 0)), 32'd16);
            chk($sformatf("fill%0d ready op0", pass), 32'(ready_out), 32'd0);
            opcode = 2'd1;
            #1;
            chk($sformatf("fill%0d ready op1", pass), 32'(ready_out), 32'd1);
            // A 17th push while full is refused.
            drive(1'b1, 2'd0, 8'hEE, 8'hEE, 2'b00);
            @(posedge clk);
            #1;
            chk($sformatf("fill%0d 17th push count0", pass), 32'(cnt(count, 0)), 32'd16);
            // Push and pop together while full: pop happens, push refused.
            @(negedge clk);
            drive(1'b1, 2'd0, 8'hDD, 8'hDD, 2'b01);
            #1;
            chk($sformatf("fill%0d full pop ready", pass), 32'(ready_out), 32'd0);
            exp_h = {2'd0, 8'(pass * 16), 8'(~(pass * 16))};
            chk($sformatf("fill%0d head 0", pass), 32'(head(instr, 0)), 32'(exp_h));
            @(posedge clk);
            #1;
            chk($sformatf("fill%0d full pop count0", pass), 32'(cnt(count, 0)), 32'd15);
            for (int i = 1; i < 16; i++) begin
                @(negedge clk);
                drive(1'b0, 2'd0, 8'h00, 8'h00, 2'b01);
                #1;
                exp_h = {2'd0, 8'(i + pass * 16), 8'(~(i + pass * 16))};
                chk($sformatf("fill%0d head %0d", pass, i), 32'(head(instr, 0)), 32'(exp_h));
            end
            @(posedge clk);
            #1;
            chk($sformatf("fill%0d drained valid0", pass), 32'(valid_out[0]), 32'd0);
        end

        // Independence: stall channel 1 with 5 entries while channel 0 streams.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, 2'd1, 8'(8'h40 + i), 8'(8'h50 + i), 2'b00);
        end
        ch1_first = {2'd1, 8'h40, 8'h50};
        model_q.delete();
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            drive(1'b1, 2'd0, 8'(8'h80 + j), 8'(8'hC0 + j), 2'b01);
            #1;
            if (valid_out[0]) begin
                if (model_q.size() == 0) chk("stream unexpected valid", 32'd1, 32'd0);
                else chk($sformatf("stream head %0d", j), 32'(head(instr, 0)),
                         32'(model_q.pop_front()));
            end
            model_q.push_back({2'd0, 8'(8'h80 + j), 8'(8'hC0 + j)});
        end
        @(negedge clk);
        drive(1'b0, 2'd0, 8'h00, 8'h00, 2'b00);
        #1;
        chk("stream backlog", 32'(model_q.size()), 32'(cnt(count, 0)));
        chk("stall count1", 32'(cnt(count, 1)), 32'd5);
        chk("stall head1", 32'(head(instr, 1)), 32'(ch1_first));
        chk("err sticky", 32'(err_illegal), 32'd1);

        // Asynchronous reset mid-cycle with both channels occupied.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst valid_out", 32'(valid_out), 32'd0);
        chk("async rst count", 32'(count), 32'd0);
        chk("async rst instr", 32'(instr[35:18]), 32'd0);
        chk("async rst err", 32'(err_illegal), 32'd0);
        chk("async rst ready_out", 32'(ready_out), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
